// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requests are granted round-robin, the operands are registered into the
// ALU, and the ALU result is captured and returned on a single response
// port tagged with the id of the requester that issued it.
// Only one operation is in flight at a time.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int FW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FW-1:0]    req0_f,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FW-1:0]    req1_f,
    output logic             req1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FW-1:0]    alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_y,
    output logic             resp_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [FW-1:0]    r_op_f;
    logic             r_op_id;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_y;
    logic             r_resp_zero;
    logic             w_grant0;
    logic             w_grant1;

    // Next-state and grant selection; a tie goes to the requester not served last.
    always_comb begin
        w_next_state = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    if (r_last_grant) begin
                        w_grant0 = 1'b1;
                    end else begin
                        w_grant1 = 1'b1;
                    end
                end else if (req0_valid) begin
                    w_grant0 = 1'b1;
                end else if (req1_valid) begin
                    w_grant1 = 1'b1;
                end else begin
                    w_grant0 = 1'b0;
                    w_grant1 = 1'b0;
                end
                if (w_grant0 || w_grant1) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Ready is combinational in the granting cycle; reset masks it so a
    // request can never look accepted on an edge where reset wins.
    always_comb begin
        if (reset) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end else begin
            req0_ready = w_grant0;
            req1_ready = w_grant1;
        end
    end

    // State, operand latch, round-robin history and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_op_a       <= {WIDTH{1'b0}};
            r_op_b       <= {WIDTH{1'b0}};
            r_op_f       <= {FW{1'b0}};
            r_op_id      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_y     <= {WIDTH{1'b0}};
            r_resp_zero  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_grant0) begin
                r_op_a       <= req0_a;
                r_op_b       <= req0_b;
                r_op_f       <= req0_f;
                r_op_id      <= 1'b0;
                r_last_grant <= 1'b0;
            end else if (w_grant1) begin
                r_op_a       <= req1_a;
                r_op_b       <= req1_b;
                r_op_f       <= req1_f;
                r_op_id      <= 1'b1;
                r_last_grant <= 1'b1;
            end else begin
                r_op_a       <= r_op_a;
                r_op_b       <= r_op_b;
                r_op_f       <= r_op_f;
                r_op_id      <= r_op_id;
                r_last_grant <= r_last_grant;
            end

            if (r_state == ST_EXEC) begin
                r_resp_y     <= alu_y;
                r_resp_zero  <= alu_zero;
                r_resp_id    <= r_op_id;
                r_resp_valid <= 1'b1;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_resp_valid <= 1'b0;
            end else begin
                r_resp_valid <= r_resp_valid;
            end
        end
    end

    // The ALU sees the operand registers directly; they hold outside EXEC.
    always_comb begin
        alu_a      = r_op_a;
        alu_b      = r_op_b;
        alu_f      = r_op_f;
        resp_valid = r_resp_valid;
        resp_id    = r_resp_id;
        resp_y     = r_resp_y;
        resp_zero  = r_resp_zero;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between two requesters. Each requester hands over an operation (a, b, f) with a valid/ready handshake. The block grants the two requesters round-robin, registers the operands into the ALU, captures y/zero into a result register, and returns the result on one response port tagged with the requester id. It sits between the requesting control units and the ALU's a/b/f inputs and y/zero outputs.

## Interface
- WIDTH, 32, operand/result width
- FW, 3, ALU function-code width (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_f  in  FW  requester 0 function code
- req0_ready  out  1  requester 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_f, req1_ready  same as requester 0, for requester 1
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_f  out  FW  registered function code to ALU
- alu_y  in  WIDTH  ALU result (combinational from alu_a/b/f)
- alu_zero  in  1  ALU zero flag
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester that issued this result
- resp_y  out  WIDTH  captured result
- resp_zero  out  1  captured zero flag

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If no req*_valid is high, stay in IDLE.
  - Otherwise grant one requester. If only one is valid, grant it. If both are valid, grant the one not in last_grant.
  - Assert the granted reqN_ready combinationally in the same cycle. The other ready stays 0.
  - On the edge: latch reqN_a/b/f into op_a/op_b/op_f, set op_id=N and last_grant=N, then go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_f equal op_a/op_b/op_f. The ALU settles within the cycle.
  - On the edge: capture alu_y into resp_y, alu_zero into resp_zero, and op_id into resp_id. Go to RESP.
- RESP:
  - resp_valid=1. resp_y, resp_zero and resp_id are held stable.
  - Stay in RESP while resp_ready=0.
  - When resp_ready=1, go to IDLE on the edge.
- All req*_ready are 0 in EXEC and RESP. Requesters must hold valid and operands until they see ready.
- Only one operation is in flight; there is no queueing.
- alu_a/alu_b/alu_f always reflect the operand registers, which hold their value outside EXEC.
- last_grant updates only on an accepted request.

## Timing
- Reset (synchronous, takes effect on the edge where reset=1):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - op_a/op_b/op_f=0, alu_a/alu_b/alu_f=0.
  - resp_valid=0, resp_id=0, resp_y=0, resp_zero=0, req0_ready=req1_ready=0.
- Reset during EXEC or RESP discards the in-flight operation. No response is produced.
- Reset has priority over every other event in the same cycle.
- Latency:
  - Request accepted at edge T (ready=1 in the cycle before T).
  - resp_valid=1 in the cycle after edge T+1.
  - With resp_ready held at 1, back-to-back throughput is one operation per 3 cycles.
- A requester that drops valid while not granted is simply not served. No state is affected.
- When a new request is valid in the cycle resp_ready completes a response, it is accepted in the following IDLE cycle, not the same cycle.
- The tie-break uses last_grant only. A lone requester is granted every time, regardless of last_grant.

## Test plan
- Reset, then req0: ADD a=5, b=3 → req0_ready in the first IDLE cycle. Two cycles later: resp_valid=1, resp_id=0, resp_y=8, resp_zero=0.
- req0 and req1 both valid from reset: req0 SUB 7-7 and req1 OR 0xF0|0x0F → first response id=0, y=0, zero=1; second response id=1, y=0xFF, zero=0.
- Both requesters hold valid continuously for 4 operations → grants alternate 0,1,0,1. No requester is granted twice in a row.
- resp_ready held at 0 for 5 cycles during RESP → resp_valid, resp_y and resp_id stay stable. Both req*_ready stay 0. The response completes one cycle after resp_ready rises.
- Reset asserted during EXEC of req1 SLT a=1, b=2 → the next cycle is IDLE, resp_valid=0, outputs are 0, and no response appears. A following req1 ADD 1+1 returns y=2, id=1.
- req1 alone issues 3 operations: AND 0xFFFF0000&0x0000FFFF → y=0, zero=1, id=1 each time. This checks that a lone requester is never blocked by last_grant.
